// File: rtl/trig_combine.sv
// trig_combine: qualifies per-channel trigger pulses into a single sample-queue
// trigger. The combine mode is ANY, ALL or a two-source sequence, and each fire
// is followed by a programmable holdoff. Configuration goes through a small
// 8-bit wishbone slave register file.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   triggers      per-channel trigger pulses (bit n = channel n)
//   sq_active     sample queue capturing; arming is only allowed while high
//   sq_trigger    one-cycle qualified trigger pulse
//   wb_*          wishbone slave: stb/cyc/we/adr/dat in, dat/ack out
//
// Register map (wb_adr_i[2:0]):
//   0 MASK, 1 MODE, 2 SEQSEL, 3/4 HOLDOFF lo/hi, 5 STATUS (ro), 6/7 COUNT lo/hi
//
// Build option: define TRIG_COMBINE_COUNTER_EN to include the saturating 16-bit
// fire counter. When it is not defined, COUNT reads 0 and writes to it are
// acknowledged and ignored.
module trig_combine #(
    parameter int NUM_SOURCES = 4,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] triggers,
    input  logic                   sq_active,
    output logic                   sq_trigger,
    input  logic                   wb_stb_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_we_i,
    input  logic [15:0]            wb_adr_i,
    input  logic [7:0]             wb_dat_i,
    output logic [7:0]             wb_dat_o,
    output logic                   wb_ack_o
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_SEQ_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    localparam logic [1:0] MODE_ALL = 2'd1;
    localparam logic [1:0] MODE_SEQ = 2'd2;

    logic [1:0]             state;
    logic [NUM_SOURCES-1:0] mask;
    logic [1:0]             mode;
    logic [2:0]             seq_first;
    logic [2:0]             seq_second;
    logic [HOLDOFF_W-1:0]   holdoff;
    logic [HOLDOFF_W-1:0]   hold_cnt;
    logic [15:0]            count_rd;

    logic       wb_req, wb_wr;
    logic [2:0] adr;
    logic       unused_adr;

    assign wb_req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_wr      = wb_req & wb_we_i;
    assign adr        = wb_adr_i[2:0];
    assign unused_adr = ^wb_adr_i[15:3];

    // Zero-extend to 8 channels so a SEQSEL index beyond NUM_SOURCES reads 0.
    logic [7:0]  trig_ext, mask_ext;
    logic [15:0] hold_ext, hold_lo_wr, hold_hi_wr;

    always_comb begin
        trig_ext = '0;
        trig_ext[NUM_SOURCES-1:0] = triggers;
        mask_ext = '0;
        mask_ext[NUM_SOURCES-1:0] = mask;
        hold_ext = '0;
        hold_ext[HOLDOFF_W-1:0] = holdoff;
    end

    assign hold_lo_wr = {hold_ext[15:8], wb_dat_i};
    assign hold_hi_wr = {wb_dat_i, hold_ext[7:0]};

    logic any_hit, all_hit, first_hit, second_hit, qual_armed, seq_abort, fire;

    assign any_hit    = |(trig_ext & mask_ext);
    assign all_hit    = (mask_ext != 8'h00) && ((trig_ext & mask_ext) == mask_ext);
    assign first_hit  = trig_ext[seq_first];
    assign second_hit = trig_ext[seq_second];
    assign seq_abort  = wb_wr && (adr == 3'd1 || adr == 3'd2);

    always_comb begin
        case (mode)
            MODE_ALL: qual_armed = all_hit;
            MODE_SEQ: qual_armed = first_hit & second_hit;
            default:  qual_armed = any_hit;   // ANY and the reserved code
        endcase
    end

    // Abort from a MODE/SEQSEL write takes priority over a same-cycle second hit.
    assign fire = sq_active &&
                  ((state == ST_ARMED && qual_armed) ||
                   (state == ST_SEQ_WAIT && !seq_abort && second_hit));

    logic [7:0] rd_data;
    always_comb begin
        case (adr)
            3'd0:    rd_data = mask_ext;
            3'd1:    rd_data = {6'd0, mode};
            3'd2:    rd_data = {1'b0, seq_second, 1'b0, seq_first};
            3'd3:    rd_data = hold_ext[7:0];
            3'd4:    rd_data = hold_ext[15:8];
            3'd5:    rd_data = {6'd0, state};
            3'd6:    rd_data = count_rd[7:0];
            default: rd_data = count_rd[15:8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sq_trigger <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 8'h00;
            mask       <= '1;
            mode       <= 2'd0;
            seq_first  <= 3'd0;
            seq_second <= 3'd1;
            holdoff    <= '0;
            hold_cnt   <= '0;
        end else begin
            wb_ack_o   <= wb_req;
            wb_dat_o   <= wb_req ? rd_data : 8'h00;
            sq_trigger <= fire;

            if (wb_wr) begin
                case (adr)
                    3'd0: mask <= wb_dat_i[NUM_SOURCES-1:0];
                    3'd1: mode <= wb_dat_i[1:0];
                    3'd2: begin
                        seq_first  <= wb_dat_i[2:0];
                        seq_second <= wb_dat_i[6:4];
                    end
                    3'd3: holdoff <= hold_lo_wr[HOLDOFF_W-1:0];
                    3'd4: holdoff <= hold_hi_wr[HOLDOFF_W-1:0];
                    default: ;
                endcase
            end

            if (!sq_active) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else if (fire) begin
                state    <= ST_HOLDOFF;
                hold_cnt <= holdoff;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARMED;
                    ST_ARMED:
                        if (mode == MODE_SEQ && first_hit) state <= ST_SEQ_WAIT;
                    ST_SEQ_WAIT:
                        if (seq_abort) state <= ST_ARMED;
                    default:
                        if (hold_cnt == '0) state <= ST_ARMED;
                        else                hold_cnt <= hold_cnt - 1'b1;
                endcase
            end
        end
    end

`ifdef TRIG_COMBINE_COUNTER_EN
    logic [15:0] count;
    always_ff @(posedge clk) begin
        if (rst)
            count <= 16'h0000;
        else if (wb_wr && adr[2:1] == 2'b11)
            count <= 16'h0000;
        else if (sq_trigger && count != 16'hFFFF)
            count <= count + 16'h0001;
    end
    assign count_rd = count;
`else
    assign count_rd = 16'h0000;
`endif

endmodule

// File: tb/tb_trig_combine.sv
module tb_trig_combine;
    localparam int NS = 4;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] triggers = '0;
    logic          sq_active = 1'b0;
    logic          sq_trigger;
    logic          wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [15:0]   wb_adr_i = '0;
    logic [7:0]    wb_dat_i = '0;
    logic [7:0]    wb_dat_o;
    logic          wb_ack_o;

    always #5 clk = ~clk;

    trig_combine #(.NUM_SOURCES(NS), .HOLDOFF_W(HW)) dut (
        .clk(clk), .rst(rst), .triggers(triggers), .sq_active(sq_active),
        .sq_trigger(sq_trigger), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Behavioural model: a timeline view. A fire on edge t blocks triggers
    // until edge t + HOLDOFF + 2; a pending sequence is a single flag.
    int edge_n = 0;
    bit m_on, m_seq, m_fire, m_ack;
    int busy_until;
    int m_rd, m_mask, m_mode, m_first, m_second, m_hold, m_count;

    always @(posedge clk) begin
        bit req, qual;
        int a, d, st, t_in, rd;
        edge_n++;
        t_in = int'(triggers);
        a    = int'(wb_adr_i[2:0]);
        d    = int'(wb_dat_i);
        req  = wb_stb_i && wb_cyc_i && !m_ack;
        if (rst) begin
            m_on = 0; m_seq = 0; m_fire = 0; m_ack = 0; m_rd = 0; busy_until = 0;
            m_mask = (1 << NS) - 1; m_mode = 0; m_first = 0; m_second = 1;
            m_hold = 0; m_count = 0;
        end else begin
            if (!m_on) st = 0;
            else if (edge_n < busy_until) st = 3;
            else if (m_seq) st = 2;
            else st = 1;
            case (a)
                0: rd = m_mask;
                1: rd = m_mode;
                2: rd = (m_second << 4) | m_first;
                3: rd = m_hold & 8'hFF;
                4: rd = m_hold >> 8;
                5: rd = st;
                6: rd = m_count & 8'hFF;
                default: rd = m_count >> 8;
            endcase
            m_ack = req;
            m_rd  = req ? rd : 0;
`ifdef TRIG_COMBINE_COUNTER_EN
            if (m_fire && m_count < 65535) m_count++;
`endif
            qual = 0;
            if (!sq_active) begin
                m_on = 0; m_seq = 0; busy_until = 0;
            end else if (!m_on) begin
                m_on = 1;
            end else if (edge_n < busy_until) begin
                qual = 0;
            end else if (m_seq) begin
                if (req && wb_we_i && (a == 1 || a == 2)) m_seq = 0;
                else if (((t_in >> m_second) & 1) == 1) qual = 1;
            end else if (m_mode == 1) begin
                qual = (m_mask != 0) && ((t_in & m_mask) == m_mask);
            end else if (m_mode == 2) begin
                if (((t_in >> m_first) & 1) == 1) begin
                    if (((t_in >> m_second) & 1) == 1) qual = 1;
                    else m_seq = 1;
                end
            end else begin
                qual = (t_in & m_mask) != 0;
            end
            if (qual) begin
                m_seq = 0;
                busy_until = edge_n + m_hold + 2;
            end
            m_fire = qual;
            if (req && wb_we_i) begin
                case (a)
                    0: m_mask = d & ((1 << NS) - 1);
                    1: m_mode = d & 3;
                    2: begin m_first = d & 7; m_second = (d >> 4) & 7; end
                    3: m_hold = ((m_hold & 16'hFF00) | d) & ((1 << HW) - 1);
                    4: m_hold = ((m_hold & 16'h00FF) | (d << 8)) & ((1 << HW) - 1);
`ifdef TRIG_COMBINE_COUNTER_EN
                    6, 7: m_count = 0;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    bit prev_trig = 0;
    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("sq_trigger", int'(sq_trigger), int'(m_fire));
            chk("wb_ack_o", int'(wb_ack_o), int'(m_ack));
            chk("wb_dat_o", int'(wb_dat_o), m_rd);
            chk("no_back_to_back", int'(prev_trig && sq_trigger), 0);
            prev_trig = sq_trigger;
        end
    end

    task automatic wb_write(input int a, input int d);
        @(negedge clk);
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 1;
        wb_adr_i = 16'(a); wb_dat_i = 8'(d);
        @(negedge clk);
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    endtask

    task automatic wb_read(input int a, output int d);
        @(negedge clk);
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 0; wb_adr_i = 16'(a);
        @(negedge clk);
        d = int'(wb_dat_o);
        wb_stb_i = 0; wb_cyc_i = 0;
    endtask

    task automatic read_chk(input string nm, input int a, input int exp);
        int d;
        wb_read(a, d);
        chk(nm, d, exp);
    endtask

    // One-cycle trigger pulse; returns at the negedge where a fire is visible.
    task automatic pulse(input int t);
        @(negedge clk) triggers = NS'(t);
        @(negedge clk) triggers = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        rst = 0;
        // reset values
        read_chk("rst_mask", 0, 8'h0F);
        read_chk("rst_mode", 1, 0);
        read_chk("rst_seqsel", 2, 8'h10);
        read_chk("rst_hold_lo", 3, 0);
        read_chk("rst_status", 5, 0);
        read_chk("rst_count", 6, 0);

        // ANY with holdoff 3
        wb_write(0, 8'h05);
        wb_write(3, 3);
        sq_active = 1;
        idle(2);
        read_chk("status_armed", 5, 1);
        pulse(4);
        chk("any_fire", int'(sq_trigger), 1);
        @(negedge clk) triggers = 4'h4;
        repeat (3) begin
            @(negedge clk);
            chk("any_holdoff_ignored", int'(sq_trigger), 0);
        end
        @(negedge clk) triggers = '0;
        chk("any_refire", int'(sq_trigger), 1);
        idle(6);
        pulse(2);
        chk("any_masked_off", int'(sq_trigger), 0);

        // ALL, mask readback truncation
        wb_write(3, 0);
        wb_write(0, 8'hFF);
        read_chk("mask_trunc", 0, 8'h0F);
        wb_write(0, 8'h03);
        wb_write(1, 1);
        pulse(1); chk("all_part1", int'(sq_trigger), 0);
        pulse(2); chk("all_part2", int'(sq_trigger), 0);
        pulse(3); chk("all_fire", int'(sq_trigger), 1);
        idle(2);
        wb_write(0, 0);
        pulse(4'hF); chk("all_mask0", int'(sq_trigger), 0);
        wb_write(1, 0);
        pulse(4'hF); chk("any_mask0", int'(sq_trigger), 0);

        // SEQ: first ch1, second ch2
        wb_write(1, 2);
        wb_write(2, 8'h21);
        pulse(2); chk("seq_first", int'(sq_trigger), 0);
        read_chk("status_seqwait", 5, 2);
        pulse(1); chk("seq_other", int'(sq_trigger), 0);
        pulse(4); chk("seq_fire", int'(sq_trigger), 1);
        idle(2);
        pulse(4); chk("seq_second_alone", int'(sq_trigger), 0);
        read_chk("status_not_waiting", 5, 1);
        pulse(6); chk("seq_same_cycle", int'(sq_trigger), 1);
        idle(2);
        pulse(2);
        wb_write(2, 8'h21);
        read_chk("status_abort", 5, 1);
        pulse(4); chk("seq_after_abort", int'(sq_trigger), 0);

        // sq_active drop during a long holdoff
        wb_write(1, 0);
        wb_write(0, 8'h0F);
        wb_write(4, 1);
        pulse(1); chk("long_fire", int'(sq_trigger), 1);
        read_chk("status_holdoff", 5, 3);
        sq_active = 0;
        idle(1);
        read_chk("status_idle", 5, 0);
        pulse(1); chk("inactive_no_fire", int'(sq_trigger), 0);
        idle(4);
        sq_active = 1;
        idle(1);
        read_chk("status_rearmed", 5, 1);
        wb_write(4, 0);

        // fire counter
        wb_write(6, 0);
        repeat (3) begin pulse(1); idle(1); end
`ifdef TRIG_COMBINE_COUNTER_EN
        read_chk("count_lo", 6, 3);
`else
        read_chk("count_lo", 6, 0);
`endif
        read_chk("count_hi", 7, 0);
        wb_write(6, 8'h55);
        read_chk("count_cleared", 6, 0);

        // reset mid-transaction and while in SEQ_WAIT
        wb_write(1, 2);
        pulse(2);
        read_chk("status_seqwait2", 5, 2);
        @(negedge clk);
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 0; wb_adr_i = 16'd5; rst = 1;
        triggers = 4'h4;
        @(negedge clk);
        chk("rst_drops_ack", int'(wb_ack_o), 0);
        chk("rst_no_fire", int'(sq_trigger), 0);
        wb_stb_i = 0; wb_cyc_i = 0; triggers = '0;
        @(negedge clk) rst = 0;
        idle(1);
        read_chk("status_after_rst", 5, 1);
        read_chk("mode_after_rst", 1, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
